// File: rtl/eight_bit_adder_if.sv
// Operand/result bundle for eight_bit_adder: operands in, combinational and
// registered results out.
interface eight_bit_adder_if #(
    parameter int unsigned N = 8
);
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         ci;
    logic [N-1:0] S;
    logic         co;
    logic         ovf;
    logic [N-1:0] S_q;
    logic         co_q;
    logic         ovf_q;

    modport master (
        output A, B, ci,
        input  S, co, ovf, S_q, co_q, ovf_q
    );

    modport slave (
        input  A, B, ci,
        output S, co, ovf, S_q, co_q, ovf_q
    );
endinterface

// File: rtl/eight_bit_adder.sv
// N-bit ripple-carry adder with carry-in. Provides a zero-latency sum/carry/overflow
// path and a one-cycle registered copy of the same results.
module eight_bit_adder #(
    parameter int unsigned N = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    eight_bit_adder_if.slave  bus
);
    logic [N-1:0] sum;
    logic         carry_out;
    logic         carry_msb_in;
    logic         overflow;

    // Each cell keeps its own carry net so the chain is an explicit ripple.
    for (genvar i = 0; i < N; i++) begin : g_cell
        logic c_in;
        logic c_out;
        logic p;

        if (i == 0) begin : g_first
            assign c_in = bus.ci;
        end else begin : g_rest
            assign c_in = g_cell[i-1].c_out;
        end

        assign p      = bus.A[i] ^ bus.B[i];
        assign sum[i] = p ^ c_in;
        assign c_out  = (bus.A[i] & bus.B[i]) | (c_in & p);
    end

    assign carry_out    = g_cell[N-1].c_out;
    assign carry_msb_in = g_cell[N-1].c_in;
    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign overflow     = carry_out ^ carry_msb_in;

    assign bus.S   = sum;
    assign bus.co  = carry_out;
    assign bus.ovf = overflow;

    logic [N-1:0] sum_d, sum_q;
    logic         co_d, co_q;
    logic         ovf_d, ovf_q;

    always_comb begin
        sum_d = sum;
        co_d  = carry_out;
        ovf_d = overflow;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            co_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            co_q  <= co_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.S_q   = sum_q;
    assign bus.co_q  = co_q;
    assign bus.ovf_q = ovf_q;
endmodule

// File: tb/tb_eight_bit_adder.sv
// Directed and pseudo-random checks of eight_bit_adder: combinational path,
// registered path and asynchronous reset behaviour.
module tb_eight_bit_adder;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    eight_bit_adder_if #(.N(8)) bus ();

    eight_bit_adder #(.N(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [8:0] act, input logic [8:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic c);
        bus.A  = a;
        bus.B  = b;
        bus.ci = c;
    endtask

    // Drive on the falling edge, check comb 1 ns later, check regs 1 ns after the rise.
    task automatic vec(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic [8:0] exp_sum, input logic exp_ovf);
        @(negedge clk);
        drive(a, b, c);
        #1;
        check_val({tag, "_sum"}, {bus.co, bus.S}, exp_sum);
        check_val({tag, "_ovf"}, {8'd0, bus.ovf}, {8'd0, exp_ovf});
        @(posedge clk);
        #1;
        check_val({tag, "_sum_q"}, {bus.co_q, bus.S_q}, exp_sum);
        check_val({tag, "_ovf_q"}, {8'd0, bus.ovf_q}, {8'd0, exp_ovf});
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic       rc;
        logic [8:0] rsum;
        logic       rovf;

        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        drive(8'd5, 8'd10, 1'b0);
        #2;
        check_val("rst_sum_q", {bus.co_q, bus.S_q}, 9'd0);
        check_val("rst_ovf_q", {8'd0, bus.ovf_q}, 9'd0);
        check_val("rst_comb_sum", {bus.co, bus.S}, 9'd15);
        @(posedge clk);
        #1;
        check_val("rst_hold_sum_q", {bus.co_q, bus.S_q}, 9'd0);
        @(negedge clk);
        rst_n = 1'b1;

        vec("v5_10",     8'd5,   8'd10,  1'b0, 9'd15,  1'b0);
        vec("v30_10",    8'd30,  8'd10,  1'b0, 9'd40,  1'b0);
        vec("v5_10_c",   8'd5,   8'd10,  1'b1, 9'd16,  1'b0);
        vec("v255_1",    8'd255, 8'd1,   1'b0, 9'h100, 1'b0);
        vec("v255_255c", 8'd255, 8'd255, 1'b1, 9'h1FF, 1'b0);
        vec("v127_1",    8'd127, 8'd1,   1'b0, 9'h080, 1'b1);
        vec("v128_128",  8'd128, 8'd128, 1'b0, 9'h100, 1'b1);
        vec("v0_0",      8'd0,   8'd0,   1'b0, 9'd0,   1'b0);
        vec("v0_0_c",    8'd0,   8'd0,   1'b1, 9'd1,   1'b0);

        // Mid-stream reset between edges: registers clear at once, comb path unaffected.
        vec("pre_rst",   8'd5,   8'd10,  1'b0, 9'd15,  1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("midrst_sum_q", {bus.co_q, bus.S_q}, 9'd0);
        check_val("midrst_ovf_q", {8'd0, bus.ovf_q}, 9'd0);
        check_val("midrst_comb",  {bus.co, bus.S}, 9'd15);
        @(posedge clk);
        #1;
        check_val("midrst_hold", {bus.co_q, bus.S_q}, 9'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("rel_before_edge", {bus.co_q, bus.S_q}, 9'd0);
        @(posedge clk);
        #1;
        check_val("rel_first_edge", {bus.co_q, bus.S_q}, 9'd15);

        for (int i = 0; i < 16; i++) begin
            ra   = 8'($urandom_range(0, 255));
            rb   = 8'($urandom_range(0, 255));
            rc   = 1'($urandom_range(0, 1));
            rsum = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            rovf = (ra[7] == rb[7]) && (rsum[7] != ra[7]);
            vec($sformatf("rnd%0d", i), ra, rb, rc, rsum, rovf);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/eight_bit_adder.md
Name: eight_bit_adder

Overview:
- N-bit (default 8) two's-complement/unsigned adder with carry-in, built as an explicit ripple-carry chain of full-adder cells.
- Provides a zero-latency combinational sum/carry path for use inside datapath logic.
- Also provides a one-cycle registered copy of sum, carry and signed-overflow for timing-closed consumers.
- Sits in the arithmetic datapath as a leaf block; no handshake.

Parameters:
- N, 8, operand and sum width in bits (legal values ≥ 2).

Ports:
- clk  input  1  rising-edge clock for the registered outputs.
- rst_n  input  1  asynchronous active-low reset; clears registered outputs only.
- A  input  N  operand A (bit pattern; signed or unsigned interpretation).
- B  input  N  operand B.
- ci  input  1  carry-in.
- S  output  N  combinational sum, (A + B + ci) mod 2^N.
- co  output  1  combinational carry-out (bit N of the unsigned sum).
- ovf  output  1  combinational signed overflow.
- S_q  output  N  S registered on clk.
- co_q  output  1  co registered on clk.
- ovf_q  output  1  ovf registered on clk.

Behaviour:
- Arithmetic: {co, S} = zero-extend(A) + zero-extend(B) + ci, computed at N+1 bits unsigned.
  - Identical bit pattern whatever the signed/unsigned view of A and B.
- Structure: N full-adder cells.
  - Cell i: s_i = a_i ^ b_i ^ c_i; c_{i+1} = a_i&b_i | c_i&(a_i^b_i).
  - c_0 = ci; co = c_N.
- ovf = c_N ^ c_{N-1}.
  - Equivalently: A[N-1] == B[N-1] and S[N-1] != A[N-1].
- Combinational outputs:
  - Zero clock latency.
  - Settle within one propagation delay of any input change.
  - No dependence on clk or rst_n.
  - No latches.
  - Valid and deterministic even while rst_n is low.
- Registered outputs:
  - On each rising clk edge with rst_n high, S_q/co_q/ovf_q capture the current S/co/ovf.
  - Latency exactly 1 cycle.
  - Throughput: one result per cycle.
- Reset:
  - rst_n low forces S_q = 0, co_q = 0, ovf_q = 0 immediately, independent of clk.
  - Outputs hold 0 while rst_n is low.
  - The first capture is on the first rising edge after rst_n deasserts.
  - Reset asserted mid-stream discards the in-flight registered result.
- Boundaries:
  - All-ones + 1 wraps to S = 0 with co = 1.
  - All-ones + all-ones + 1 gives S = all-ones with co = 1.
  - Zero + zero + 0 gives all outputs 0.
- Inputs are sampled as-is; there is no input registering and no enable.

Test Plan:
- A=5, B=10, ci=0 -> S=15, co=0, ovf=0 within 1 ns; after the next clk edge, S_q=15, co_q=0.
- A=30, B=10, ci=0 -> S=40, co=0; then A=5, B=10, ci=1 -> S=16, co=0.
- A=255, B=1, ci=0 -> S=0, co=1, ovf=0; A=255, B=255, ci=1 -> S=255, co=1.
- A=127, B=1, ci=0 -> S=128 (0x80), co=0, ovf=1; A=128, B=128, ci=0 -> S=0, co=1, ovf=1.
- Reset: run with A=5, B=10, then pull rst_n low between clock edges.
  - S_q/co_q/ovf_q go to 0 immediately, while S stays 15.
  - After release, S_q returns to 15 on the first rising edge.
- Random: 10+ iterations with ci in {0,1} and A, B in the signed range -128..127, inputs changed each cycle.
  - Check {co, S} == A + B + ci (9-bit unsigned) 1 ns after each change.
  - Check the registered outputs one cycle later.
